// File: rtl/bin2bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD digit converter.
package bin2bcd_pkg;

    localparam int DIGITS  = 8;
    localparam int DIGIT_W = 5;
    localparam int EN_BIT  = 4;

    localparam logic [26:0] BCD_MAX  = 27'd99_999_999;
    localparam logic [3:0]  ERR_CODE = 4'hE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_digits_if.sv
// Handshake and digit-output bundle between the value source and the converter.
interface bin2bcd_digits_if #(
    parameter int DATA_W = 27
);
    import bin2bcd_pkg::*;

    logic [DATA_W-1:0]  data_i;
    logic               valid_i;
    logic               ready_o;
    logic               done_o;
    logic               ovf_o;
    logic [DIGIT_W-1:0] hex0_o;
    logic [DIGIT_W-1:0] hex1_o;
    logic [DIGIT_W-1:0] hex2_o;
    logic [DIGIT_W-1:0] hex3_o;
    logic [DIGIT_W-1:0] hex4_o;
    logic [DIGIT_W-1:0] hex5_o;
    logic [DIGIT_W-1:0] hex6_o;
    logic [DIGIT_W-1:0] hex7_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, done_o, ovf_o,
        input  hex0_o, hex1_o, hex2_o, hex3_o, hex4_o, hex5_o, hex6_o, hex7_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, done_o, ovf_o,
        output hex0_o, hex1_o, hex2_o, hex3_o, hex4_o, hex5_o, hex6_o, hex7_o
    );

endinterface

// File: rtl/bcd_adj_nibble.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_adj_nibble (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/bin2bcd_digits.sv
// Sequential double-dabble converter feeding an 8-digit seven-segment driver,
// with leading-zero blanking and an overflow ("E") indication.
//
// state   | meaning
// IDLE    | ready for a new value, outputs hold the last result
// CONVERT | one add-3/shift step per cycle, DATA_W steps total
// DONE    | publish digits, pulse done, return to IDLE
module bin2bcd_digits
    import bin2bcd_pkg::*;
#(
    parameter int DATA_W = 27,
    parameter bit BLANK  = 1'b1
) (
    input logic             clk_i,
    input logic             rst_i,
    bin2bcd_digits_if.slave bus
);

    localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    state_t             state;
    logic [DATA_W-1:0]  bin_q;
    logic [31:0]        bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               ready_q;
    logic               done_q;
    logic               ovf_out_q;
    logic [DIGIT_W-1:0] hex_q [DIGITS];

    logic [31:0]        bcd_adj;
    logic [DIGIT_W-1:0] hex_d [DIGITS];
    logic               seen_nz;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj_nibble u_adj (
            .nibble   (bcd_q[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // Scan from the most significant digit so each digit knows whether
    // anything nonzero sits at or above it.
    always_comb begin
        seen_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hex_d[k] = '0;
            seen_nz  = seen_nz | (bcd_q[4*k +: 4] != 4'd0);
            if (!BLANK || (k == 0) || seen_nz) begin
                hex_d[k][EN_BIT] = 1'b1;
                hex_d[k][3:0]    = bcd_q[4*k +: 4];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            for (int k = 0; k < DIGITS; k++) begin
                hex_q[k] <= '0;
            end
            hex_q[0][EN_BIT] <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        bin_q   <= bus.data_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= (32'(bus.data_i) > 32'(BCD_MAX));
                        ready_q <= 1'b0;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (ovf_q) begin
                            hex_q[k] <= (k == 0) ? {1'b1, ERR_CODE} : '0;
                        end else begin
                            hex_q[k] <= hex_d[k];
                        end
                    end
                    ovf_out_q <= ovf_q;
                    done_q    <= 1'b1;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.done_o  = done_q;
    assign bus.ovf_o   = ovf_out_q;
    assign bus.hex0_o  = hex_q[0];
    assign bus.hex1_o  = hex_q[1];
    assign bus.hex2_o  = hex_q[2];
    assign bus.hex3_o  = hex_q[3];
    assign bus.hex4_o  = hex_q[4];
    assign bus.hex5_o  = hex_q[5];
    assign bus.hex6_o  = hex_q[6];
    assign bus.hex7_o  = hex_q[7];

endmodule

// File: tb/tb_bin2bcd_digits.sv
// Scoreboard bench: a blanking and a non-blanking converter see the same stimulus;
// results are checked against decimal arithmetic on every done pulse.
module tb_bin2bcd_digits;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin2bcd_digits_if #(.DATA_W(27)) bus ();
    bin2bcd_digits_if #(.DATA_W(27)) bus_nb ();

    assign bus_nb.data_i  = bus.data_i;
    assign bus_nb.valid_i = bus.valid_i;

    bin2bcd_digits #(.DATA_W(27), .BLANK(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    bin2bcd_digits #(.DATA_W(27), .BLANK(1'b0)) dut_nb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_nb)
    );

    wire [39:0] hex_m = {bus.hex7_o, bus.hex6_o, bus.hex5_o, bus.hex4_o,
                         bus.hex3_o, bus.hex2_o, bus.hex1_o, bus.hex0_o};
    wire [39:0] hex_n = {bus_nb.hex7_o, bus_nb.hex6_o, bus_nb.hex5_o, bus_nb.hex4_o,
                         bus_nb.hex3_o, bus_nb.hex2_o, bus_nb.hex1_o, bus_nb.hex0_o};

    int          checks = 0;
    int          errors = 0;
    longint      cyc    = 0;
    logic [26:0] exp_q [$];
    longint      acc_q [$];
    bit          prev_done = 1'b0;
    logic [39:0] prev_hex  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: digit k is (v / 10^k) % 10, and it is shown when v >= 10^k.
    function automatic logic [39:0] model_hex(input longint v, input bit blank);
        logic [39:0] r;
        longint      p;
        r = '0;
        p = 1;
        if (v > 99999999) return {35'd0, 5'h1E};
        for (int k = 0; k < 8; k++) begin
            if (!blank || k == 0 || v >= p) r[5*k +: 5] = {1'b1, 4'((v / p) % 10)};
            p = p * 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
            prev_hex  = hex_m;
        end else begin
            if (bus.done_o) begin
                chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: hex %0h with nothing outstanding", hex_m);
                end else begin
                    logic [26:0] v;
                    longint      t;
                    v = exp_q.pop_front();
                    t = acc_q.pop_front();
                    chk("hex_blank",   {24'd0, hex_m}, {24'd0, model_hex(longint'(v), 1'b1)});
                    chk("hex_noblank", {24'd0, hex_n}, {24'd0, model_hex(longint'(v), 1'b0)});
                    chk("ovf",         {63'd0, bus.ovf_o},    {63'd0, (v > 27'd99999999)});
                    chk("ovf_noblank", {63'd0, bus_nb.ovf_o}, {63'd0, (v > 27'd99999999)});
                    chk("latency",     64'(cyc - t), 64'd28);
                    chk("ready_at_done", {63'd0, bus.ready_o}, 64'd1);
                end
            end else if (!bus.ready_o) begin
                chk("hold_during_convert", {24'd0, hex_m}, {24'd0, prev_hex});
            end
            prev_done = bus.done_o;
            prev_hex  = hex_m;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [26:0] v, output longint edge_no);
        bit acc;
        acc     = 1'b0;
        edge_no = -1;
        bus.data_i  = v;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (bus.ready_o) begin
                acc     = 1'b1;
                edge_no = cyc + 1;
                exp_q.push_back(v);
                acc_q.push_back(cyc + 1);
            end
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: value %0d never accepted", v);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.ready_o) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_hex"},    {24'd0, hex_m}, 64'h10);
        chk({tag, "_hex_nb"}, {24'd0, hex_n}, 64'h10);
        chk({tag, "_ready"},  {63'd0, bus.ready_o}, 64'd1);
        chk({tag, "_done"},   {63'd0, bus.done_o},  64'd0);
        chk({tag, "_ovf"},    {63'd0, bus.ovf_o},   64'd0);
    endtask

    initial begin
        longint e1, e2;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("idle");

        send(27'd12345678, e1);
        wait_idle();
        chk("digits_12345678", {24'd0, hex_m},
            {24'd0, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18});

        // Abort a conversion with reset; nothing may be published.
        send(27'd12345678, e1);
        repeat (10) @(negedge clk);
        exp_q.delete();
        acc_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_reset_state("abort_idle");

        send(27'd100, e1);
        send(27'd0, e1);
        send(27'd99999999, e1);
        send(27'd100000000, e1);
        send(27'd5, e1);
        wait_idle();
        chk("ovf_cleared", {63'd0, bus.ovf_o}, 64'd0);
        chk("hex0_after_5", {59'd0, bus.hex0_o}, 64'h15);

        // 42 is held while busy, then 7 is offered during its conversion.
        send(27'd1, e1);
        send(27'd42, e1);
        bus.data_i  = 27'd7;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("busy_ready_low", {63'd0, bus.ready_o}, 64'd0);
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        wait_idle();

        send(27'd314159, e1);
        send(27'd2718, e2);
        chk("issue_spacing", 64'(e2 - e1), 64'd29);
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            logic [26:0] v;
            case ($urandom_range(0, 3))
                0:       v = 27'($urandom_range(0, 999));
                1:       v = 27'($urandom_range(100000000, 134217727));
                default: v = 27'($urandom_range(0, 99999999));
            endcase
            send(v, e1);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
